eic_ahb_ctrl: RTL and testbench

AHB-Lite slave register file that configures and services the external interrupt controller. It drives the per-channel mask, the sense-mode selects, and the forced request write strobes/values into the channel array. It reads back live request flags and the encoded interrupt number. It also clears the serviced request when the core acknowledges an interrupt.

---
 rtl/eic_ahb_ctrl.sv | 102 ++++++++++
 tb/tb_eic_ahb_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/eic_ahb_ctrl.sv
// eic_ahb_ctrl: AHB-Lite register file configuring the EIC channel array
// (mask, sense modes, forced request writes) and clearing acknowledged requests.
module eic_ahb_ctrl #(
    parameter int EIC_DIRECT_CHANNELS = 32,
    parameter int EIC_SENSE_CHANNELS  = 32,
    localparam int EIC_TOTAL_CHANNELS = EIC_DIRECT_CHANNELS + EIC_SENSE_CHANNELS
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            HSEL,
    input  logic [5:0]                      HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic                            HREADY,
    input  logic [31:0]                     HWDATA,
    output logic [31:0]                     HRDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    input  logic [EIC_TOTAL_CHANNELS-1:0]   request,
    input  logic [5:0]                      irqNumber,
    input  logic                            EIC_IAck,
    output logic [EIC_TOTAL_CHANNELS-1:0]   mask,
    output logic [2*EIC_SENSE_CHANNELS-1:0] sense,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestWR,
    output logic [EIC_TOTAL_CHANNELS-1:0]   requestIn
);
    localparam logic [63:0] VMASK  = (EIC_TOTAL_CHANNELS >= 64) ? '1 : ((64'd1 << EIC_TOTAL_CHANNELS) - 64'd1);
    localparam logic [63:0] VSENSE = (2*EIC_SENSE_CHANNELS >= 64) ? '1 : ((64'd1 << (2*EIC_SENSE_CHANNELS)) - 64'd1);
    logic        r_cfg;
    logic [63:0] r_mask;
    logic [63:0] r_sense;
    logic [63:0] r_req_wr;
    logic [63:0] r_req_in;
    logic        r_wr_en;
    logic        r_rd_en;
    logic [3:0]  r_idx;
    logic        w_acc;
    logic [63:0] w_req;
    logic [63:0] w_set;
    logic [63:0] w_clr;
    logic [63:0] w_ack;
    logic        w_unused;
    assign w_unused  = &{1'b0, HADDR[1:0], HTRANS[0]};
    assign w_acc     = HSEL & HREADY & HTRANS[1];
    assign w_req     = 64'(request);
    assign w_set     = (r_wr_en && r_idx == 4'd6) ? {32'd0, HWDATA} :
                       (r_wr_en && r_idx == 4'd7) ? {HWDATA, 32'd0} : 64'd0;
    assign w_clr     = (r_wr_en && r_idx == 4'd8) ? {32'd0, HWDATA} :
                       (r_wr_en && r_idx == 4'd9) ? {HWDATA, 32'd0} : 64'd0;
    assign w_ack     = (EIC_IAck && irqNumber != 6'd0) ? (64'd1 << (irqNumber - 6'd1)) : 64'd0;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign mask      = r_mask[EIC_TOTAL_CHANNELS-1:0] & {EIC_TOTAL_CHANNELS{r_cfg}};
    assign sense     = r_sense[2*EIC_SENSE_CHANNELS-1:0];
    assign requestWR = r_req_wr[EIC_TOTAL_CHANNELS-1:0];
    assign requestIn = r_req_in[EIC_TOTAL_CHANNELS-1:0];
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cfg    <= 1'b0;
            r_mask   <= '0;
            r_sense  <= '0;
            r_req_wr <= '0;
            r_req_in <= '0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_wr_en  <= w_acc & HWRITE;
            r_rd_en  <= w_acc & ~HWRITE;
            if (w_acc) r_idx <= HADDR[5:2];
            // bus set/clear overrides the ack because requestIn only carries the bus set bits
            r_req_wr <= (w_set | w_clr | w_ack) & VMASK;
            r_req_in <= w_set & VMASK;
            if (r_wr_en) begin
                case (r_idx)
                    4'd0:    r_cfg           <= HWDATA[0];
                    4'd2:    r_mask[31:0]    <= HWDATA & VMASK[31:0];
                    4'd3:    r_mask[63:32]   <= HWDATA & VMASK[63:32];
                    4'd10:   r_sense[31:0]   <= HWDATA & VSENSE[31:0];
                    4'd11:   r_sense[63:32]  <= HWDATA & VSENSE[63:32];
                    default: ;
                endcase
            end
        end
    end
    always_comb begin
        HRDATA = '0;
        if (r_rd_en) begin
            case (r_idx)
                4'd0:    HRDATA = {31'd0, r_cfg};
                4'd1:    HRDATA = {23'd0, |request, 2'd0, irqNumber};
                4'd2:    HRDATA = r_mask[31:0];
                4'd3:    HRDATA = r_mask[63:32];
                4'd4:    HRDATA = w_req[31:0];
                4'd5:    HRDATA = w_req[63:32];
                4'd10:   HRDATA = r_sense[31:0];
                4'd11:   HRDATA = r_sense[63:32];
                default: HRDATA = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_eic_ahb_ctrl.sv
// tb_eic_ahb_ctrl: directed and randomized checks of eic_ahb_ctrl against a
// register-level reference model.
module tb_eic_ahb_ctrl;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [5:0]  HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] request = '0;
    logic [5:0]  irqNumber = '0;
    logic        EIC_IAck = 1'b0;
    logic [63:0] mask;
    logic [63:0] sense;
    logic [63:0] requestWR;
    logic [63:0] requestIn;

    eic_ahb_ctrl dut (
        .CLK(CLK), .RESET(RESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .request(request), .irqNumber(irqNumber),
        .EIC_IAck(EIC_IAck), .mask(mask), .sense(sense), .requestWR(requestWR),
        .requestIn(requestIn)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    logic        m_cfg;
    logic [63:0] m_mask;
    logic [63:0] m_sense;
    logic [63:0] e_wr;
    logic [63:0] e_in;
    logic [31:0] rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int idx);
        case (idx)
            0:  return {31'd0, m_cfg};
            1:  return {23'd0, (request != 64'd0), 2'd0, irqNumber};
            2:  return m_mask[31:0];
            3:  return m_mask[63:32];
            4:  return request[31:0];
            5:  return request[63:32];
            10: return m_sense[31:0];
            11: return m_sense[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d);
        e_wr = 64'd0;
        e_in = 64'd0;
        case (idx)
            0:  m_cfg = d[0];
            2:  m_mask[31:0] = d;
            3:  m_mask[63:32] = d;
            6:  begin e_wr = {32'd0, d}; e_in = {32'd0, d}; end
            7:  begin e_wr = {d, 32'd0}; e_in = {d, 32'd0}; end
            8:  e_wr = {32'd0, d};
            9:  e_wr = {d, 32'd0};
            10: m_sense[31:0] = d;
            11: m_sense[63:32] = d;
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_cfg = 1'b0;
        m_mask = '0;
        m_sense = '0;
    endtask

    task automatic addr_phase(input int idx, input logic wr);
        logic [3:0] w;
        w = idx[3:0];
        HSEL = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR = {w, 2'($urandom)};
    endtask

    task automatic bus_idle();
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // returns #1 after the edge ending the data phase, i.e. in the strobe cycle
    task automatic bus_write(input int idx, input logic [31:0] d);
        addr_phase(idx, 1'b1);
        @(posedge CLK); #1;
        HWDATA = d;
        bus_idle();
        @(posedge CLK); #1;
    endtask

    // returns inside the read data phase
    task automatic bus_read(input int idx, output logic [31:0] d);
        addr_phase(idx, 1'b0);
        @(posedge CLK); #1;
        bus_idle();
        d = HRDATA;
    endtask

    initial begin
        m_reset();
        request = {$urandom, $urandom};
        irqNumber = 6'd9;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("reset_mask", mask, 64'd0);
        chk("reset_reqwr", requestWR, 64'd0);
        chk("reset_hrdata_idle", {32'd0, HRDATA}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            bus_read(i, rd);
            chk($sformatf("reset_rd%0d", i), {32'd0, rd}, {32'd0, exp_rd(i)});
        end
        chk("reset_sense", sense, 64'd0);

        m_write(2, 32'h0000_00F0);
        bus_write(2, 32'h0000_00F0);
        chk("mask_disabled", mask, 64'd0);
        m_write(0, 32'h1);
        bus_write(0, 32'h1);
        chk("mask_enabled", mask, 64'h0000_0000_0000_00F0);
        bus_read(2, rd);
        chk("mask_l_rd", {32'd0, rd}, 64'h0000_00F0);

        bus_write(7, 32'h0000_0003);
        chk("ifrs_h_wr", requestWR, 64'h3_0000_0000);
        chk("ifrs_h_in", requestIn, 64'h3_0000_0000);
        @(posedge CLK); #1;
        chk("ifrs_h_once", requestWR, 64'd0);

        bus_write(8, 32'h8000_0001);
        chk("ifrc_l_wr", requestWR, 64'h8000_0001);
        chk("ifrc_l_in", requestIn, 64'd0);

        irqNumber = 6'd6;
        EIC_IAck = 1'b1;
        @(posedge CLK); #1;
        EIC_IAck = 1'b0;
        chk("ack_wr", requestWR, 64'd1 << 5);
        chk("ack_in", requestIn, 64'd0);
        @(posedge CLK); #1;
        chk("ack_once", requestWR, 64'd0);
        irqNumber = 6'd0;
        EIC_IAck = 1'b1;
        @(posedge CLK); #1;
        EIC_IAck = 1'b0;
        chk("ack_none", requestWR, 64'd0);

        irqNumber = 6'd3;
        addr_phase(6, 1'b1);
        @(posedge CLK); #1;
        bus_idle();
        HWDATA = 32'h4;
        EIC_IAck = 1'b1;
        @(posedge CLK); #1;
        EIC_IAck = 1'b0;
        chk("ack_vs_ifrs_wr", requestWR, 64'h4);
        chk("ack_vs_ifrs_in", requestIn, 64'h4);

        addr_phase(6, 1'b1);
        @(posedge CLK); #1;
        bus_idle();
        HWDATA = 32'h1;
        EIC_IAck = 1'b1;
        @(posedge CLK); #1;
        EIC_IAck = 1'b0;
        chk("ack_merge_wr", requestWR, 64'h5);
        chk("ack_merge_in", requestIn, 64'h1);

        m_write(11, 32'hA5A5_A5A5);
        addr_phase(11, 1'b1);
        @(posedge CLK); #1;
        HWDATA = 32'hA5A5_A5A5;
        addr_phase(11, 1'b0);
        @(posedge CLK); #1;
        bus_idle();
        chk("b2b_rd", {32'd0, HRDATA}, 64'hA5A5_A5A5);
        chk("b2b_sense", sense, m_sense);
        chk("b2b_sense_hi", sense[63:32], 64'hA5A5_A5A5);

        addr_phase(11, 1'b1);
        @(posedge CLK); #1;
        bus_idle();
        HWDATA = 32'h1234_5678;
        RESET = 1'b1;
        m_reset();
        #2 RESET = 1'b0;
        chk("rst_mid_mask", mask, 64'd0);
        @(posedge CLK); #1;
        chk("rst_mid_reqwr", requestWR, 64'd0);
        bus_read(11, rd);
        chk("rst_mid_sense1", {32'd0, rd}, 64'd0);
        bus_read(0, rd);
        chk("rst_mid_cfg", {32'd0, rd}, 64'd0);

        for (int n = 0; n < 80; n++) begin
            int idx;
            logic [31:0] d;
            request = {$urandom, $urandom};
            irqNumber = 6'($urandom_range(0, 63));
            idx = $urandom_range(0, 15);
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                m_write(idx, d);
                bus_write(idx, d);
                chk($sformatf("rnd%0d_wr_strobe_w%0d", n, idx), requestWR, e_wr);
                chk($sformatf("rnd%0d_wr_in_w%0d", n, idx), requestIn, e_in);
                chk($sformatf("rnd%0d_mask", n), mask, m_cfg ? m_mask : 64'd0);
            end else begin
                bus_read(idx, rd);
                chk($sformatf("rnd%0d_rd_w%0d", n, idx), {32'd0, rd}, {32'd0, exp_rd(idx)});
                chk($sformatf("rnd%0d_rd_nostrobe", n), requestWR, 64'd0);
            end
        end
        chk("final_sense", sense, m_sense);
        chk("hready_hresp", {62'd0, HREADYOUT, HRESP}, 64'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
